// File: rtl/seq_mult8_ctrl.sv
// seq_mult8_ctrl
//   Sequential unsigned multiplier. It computes a WIDTH x WIDTH product with one
//   (WIDTH/2)x(WIDTH/2) multiplier. Each cycle it forms one partial product and
//   adds it, shifted, into a 2*WIDTH accumulator. Requests are serialised with
//   valid/ready handshakes, and only one result is in flight at a time.
//
// Parameters
//   WIDTH      operand width (even, >= 4); the product is 2*WIDTH bits
//   EARLY_ZERO 1 = a zero operand skips the partial-product steps
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair valid
//   in_ready   block can accept an operand pair (IDLE only)
//   a, b       unsigned operands, captured on accept
//   out_valid  product valid (DONE)
//   out_ready  consumer accepts the product
//   p          product; holds the last result until the next completion
//   busy       high whenever the FSM is not IDLE
module seq_mult8_ctrl #(
   parameter int unsigned WIDTH      = 8,
   parameter bit          EARLY_ZERO = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] p,
   output logic               busy
);

   localparam int unsigned H  = WIDTH / 2;
   localparam int unsigned PW = 2 * WIDTH;

   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic [PW-1:0]    acc_q, p_q;
   logic [1:0]       step_q;
   logic             in_ready_q, out_valid_q, busy_q;

   logic [H-1:0]     mul_x, mul_y;
   logic [WIDTH-1:0] prod;
   logic [PW-1:0]    prod_ext, term, sum_d;
   logic             zero_op;

   // Select the operand halves for the current step: LL, LH, HL, HH.
   always_comb begin
      mul_x = a_q[H-1:0];
      mul_y = b_q[H-1:0];
      case (step_q)
         2'd1: mul_y = b_q[WIDTH-1:H];
         2'd2: mul_x = a_q[WIDTH-1:H];
         2'd3: begin
            mul_x = a_q[WIDTH-1:H];
            mul_y = b_q[WIDTH-1:H];
         end
         default: ;
      endcase
   end

   assign prod     = WIDTH'(mul_x) * WIDTH'(mul_y);
   assign prod_ext = {{WIDTH{1'b0}}, prod};

   // Each middle term is added on its own step, so no (H+1)-bit cross sum is needed.
   always_comb begin
      term = prod_ext;
      case (step_q)
         2'd1, 2'd2: term = prod_ext << H;
         2'd3:       term = prod_ext << (2 * H);
         default:    term = prod_ext;
      endcase
   end

   assign sum_d   = acc_q + term;
   assign zero_op = (a_q == '0) || (b_q == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         acc_q       <= '0;
         p_q         <= '0;
         step_q      <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q        <= a;
                  b_q        <= b;
                  acc_q      <= '0;
                  step_q     <= '0;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= MUL;
               end
            end
            MUL: begin
               // The zero test is made on the registered operands in the first
               // MUL cycle, so the shortcut completes one cycle after accept.
               if (EARLY_ZERO && (step_q == 2'd0) && zero_op) begin
                  p_q         <= '0;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  acc_q  <= sum_d;
                  step_q <= step_q + 2'd1;
                  if (step_q == 2'd3) begin
                     p_q         <= sum_d;
                     out_valid_q <= 1'b1;
                     state_q     <= DONE;
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q     <= IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign p         = p_q;
   assign busy      = busy_q;

endmodule
